// File: rtl/txfifo_rd_ctrl.sv
// Store-and-forward read controller for the TX FIFO. It pops a frame header,
// waits until the whole frame is resident, then streams it to the MAC TX port.
module txfifo_rd_ctrl #(
    parameter int WIDTH   = 64,
    parameter int PTR     = 10,
    parameter int MAX_LEN = 8184
) (
    input  logic             clk,
    input  logic             aclr,
    output logic             fifo_rdreq,
    input  logic [WIDTH-1:0] fifo_q,
    input  logic             fifo_rdempty,
    input  logic [PTR:0]     fifo_rdusedw,
    output logic [WIDTH-1:0] tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             tx_sop,
    output logic             tx_eop,
    output logic [2:0]       tx_mod,
    output logic             len_err
);

    localparam int          CW        = 13;
    localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_WAIT,
        S_DATA,
        S_ERR
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    nwords_q, nwords_d;
    logic [CW-1:0]    rd_cnt_q, rd_cnt_d;
    logic [CW-1:0]    tx_cnt_q, tx_cnt_d;
    logic [2:0]       mod_q, mod_d;
    logic             len_err_q, len_err_d;
    logic             inflight_q, inflight_d;
    logic [WIDTH-1:0] skid0_q, skid0_d;
    logic [WIDTH-1:0] skid1_q, skid1_d;
    logic [1:0]       occ_q, occ_d;

    logic [15:0]      hdr_len;
    logic [16:0]      hdr_sum;
    logic [CW-1:0]    hdr_nwords;
    logic             hdr_bad;
    logic             unused_bits;
    logic             frame_resident;
    logic             head_valid;
    logic [WIDTH-1:0] head_data;
    logic             accept;
    logic             push;
    logic             last_word;

    // Header: length in bytes in [15:0]; the upper bits are reserved.
    assign hdr_len     = fifo_q[15:0];
    assign hdr_sum     = {1'b0, hdr_len} + 17'd7;
    assign hdr_nwords  = hdr_sum[CW+2:3];
    assign hdr_bad     = (hdr_len == 16'd0) || (hdr_len > MAX_LEN_W);
    assign unused_bits = ^{fifo_q[WIDTH-1:16], hdr_sum[16], hdr_sum[2:0]};

    assign frame_resident = {{(CW-PTR-1){1'b0}}, fifo_rdusedw} >= nwords_q;

    // A word returning from the FIFO bypasses an empty skid buffer, which
    // gives first-word latency of one cycle after its read request.
    assign push       = inflight_q;
    assign head_valid = (state_q == S_DATA) && ((occ_q != 2'd0) || inflight_q);
    assign head_data  = (occ_q != 2'd0) ? skid0_q : (inflight_q ? fifo_q : '0);
    assign accept     = head_valid && tx_ready;
    assign last_word  = (tx_cnt_q == 13'd1);

    // NOTE: state registers use non-blocking assignments and the async reset
    // in the sensitivity list, so every flop updates from pre-edge values.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (!fifo_rdempty) state_d = S_HDR;
            S_HDR:  state_d = hdr_bad ? S_ERR : S_WAIT;
            S_WAIT: if (frame_resident) state_d = S_DATA;
            S_DATA: if (accept && last_word) state_d = S_IDLE;
            S_ERR:  state_d = S_ERR;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        fifo_rdreq = 1'b0;
        tx_valid   = head_valid;
        tx_data    = head_data;
        tx_sop     = head_valid && (tx_cnt_q == nwords_q);
        tx_eop     = head_valid && last_word;
        tx_mod     = (head_valid && last_word) ? mod_q : 3'd0;
        len_err    = len_err_q;
        case (state_q)
            S_IDLE: fifo_rdreq = !fifo_rdempty;
            S_DATA: fifo_rdreq = (rd_cnt_q != '0) && !fifo_rdempty &&
                                 ((occ_q + {1'b0, inflight_q}) < 2'd2);
            default: fifo_rdreq = 1'b0;
        endcase
    end

    always_comb begin
        nwords_d   = nwords_q;
        rd_cnt_d   = rd_cnt_q;
        tx_cnt_d   = tx_cnt_q;
        mod_d      = mod_q;
        len_err_d  = len_err_q;
        skid0_d    = skid0_q;
        skid1_d    = skid1_q;
        occ_d      = occ_q;
        inflight_d = (state_q == S_DATA) && fifo_rdreq;

        if (state_q == S_HDR) begin
            if (hdr_bad) begin
                len_err_d = 1'b1;
            end else begin
                nwords_d = hdr_nwords;
                rd_cnt_d = hdr_nwords;
                tx_cnt_d = hdr_nwords;
                mod_d    = hdr_len[2:0];
            end
        end
        if (inflight_d) rd_cnt_d = rd_cnt_q - 13'd1;
        if (accept)     tx_cnt_d = tx_cnt_q - 13'd1;

        case ({push, accept})
            2'b10: begin
                if (occ_q == 2'd0) skid0_d = fifo_q;
                else               skid1_d = fifo_q;
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                skid0_d = skid1_q;
                occ_d   = occ_q - 2'd1;
            end
            2'b11: begin
                // Pop and push together keep the occupancy unchanged.
                if (occ_q == 2'd1) begin
                    skid0_d = fifo_q;
                end else if (occ_q == 2'd2) begin
                    skid0_d = skid1_q;
                    skid1_d = fifo_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            nwords_q   <= '0;
            rd_cnt_q   <= '0;
            tx_cnt_q   <= '0;
            mod_q      <= '0;
            len_err_q  <= 1'b0;
            inflight_q <= 1'b0;
            skid0_q    <= '0;
            skid1_q    <= '0;
            occ_q      <= '0;
        end else begin
            nwords_q   <= nwords_d;
            rd_cnt_q   <= rd_cnt_d;
            tx_cnt_q   <= tx_cnt_d;
            mod_q      <= mod_d;
            len_err_q  <= len_err_d;
            inflight_q <= inflight_d;
            skid0_q    <= skid0_d;
            skid1_q    <= skid1_d;
            occ_q      <= occ_d;
        end
    end

endmodule

// File: tb/tb_txfifo_rd_ctrl.sv
// Directed bench for txfifo_rd_ctrl: a behavioural non-FWFT FIFO feeds the DUT
// and a negedge monitor records every word the MAC side accepts.
module tb_txfifo_rd_ctrl;

    logic        clk = 1'b0;
    logic        aclr;
    logic        fifo_rdreq;
    logic [63:0] fifo_q = '0;
    logic        fifo_rdempty;
    logic [10:0] fifo_rdusedw;
    logic [63:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_sop;
    logic        tx_eop;
    logic [2:0]  tx_mod;
    logic        len_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    txfifo_rd_ctrl #(.WIDTH(64), .PTR(10), .MAX_LEN(8184)) dut (
        .clk          (clk),
        .aclr         (aclr),
        .fifo_rdreq   (fifo_rdreq),
        .fifo_q       (fifo_q),
        .fifo_rdempty (fifo_rdempty),
        .fifo_rdusedw (fifo_rdusedw),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .tx_sop       (tx_sop),
        .tx_eop       (tx_eop),
        .tx_mod       (tx_mod),
        .len_err      (len_err)
    );

    // FIFO model: writes come from the stimulus, reads from the DUT.
    logic [63:0] mem [0:1023];
    logic [10:0] wr_ptr = '0;
    logic [10:0] rd_ptr = '0;
    logic        bad_read = 1'b0;

    assign fifo_rdusedw = wr_ptr - rd_ptr;
    assign fifo_rdempty = (fifo_rdusedw == 11'd0);

    always @(posedge clk or posedge aclr) begin
        if (aclr) begin
            rd_ptr <= '0;
            fifo_q <= '0;
        end else if (fifo_rdreq) begin
            if (fifo_rdempty) begin
                bad_read <= 1'b1;
            end else begin
                fifo_q <= mem[rd_ptr[9:0]];
                rd_ptr <= rd_ptr + 11'd1;
            end
        end
    end

    // MAC-side monitor
    int          cyc      = 0;
    int          hold_err = 0;
    int          max_occ  = 0;
    logic        p_stall  = 1'b0;
    logic [63:0] p_data   = '0;
    logic [4:0]  p_frm    = '0;
    logic [63:0] m_data [$];
    logic        m_sop  [$];
    logic        m_eop  [$];
    logic [2:0]  m_mod  [$];
    int          m_cyc  [$];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (p_stall && !(tx_valid && (tx_data === p_data) && ({tx_sop, tx_eop, tx_mod} === p_frm)))
            hold_err <= hold_err + 1;
        p_stall <= tx_valid && !tx_ready;
        p_data  <= tx_data;
        p_frm   <= {tx_sop, tx_eop, tx_mod};
        if (int'(dut.occ_q) > max_occ) max_occ <= int'(dut.occ_q);
        if (tx_valid && tx_ready) begin
            m_data.push_back(tx_data);
            m_sop.push_back(tx_sop);
            m_eop.push_back(tx_eop);
            m_mod.push_back(tx_mod);
            m_cyc.push_back(cyc);
        end
    end

    function automatic logic [63:0] dw(input int f, input int i);
        return {16'hDA7A, 16'(f), 16'h0000, 16'(i)};
    endfunction

    function automatic logic [63:0] hdr(input int len);
        return {48'hC0DE_5EED_0000, 16'(len)};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [63:0] w);
        mem[wr_ptr[9:0]] = w;
        wr_ptr = wr_ptr + 11'd1;
    endtask

    task automatic load_frame(input int f, input int len, input int nw);
        push(hdr(len));
        for (int i = 0; i < nw; i++) push(dw(f, i));
    endtask

    task automatic pulse_aclr();
        aclr   = 1'b1;
        wr_ptr = '0;
        #1;
    endtask

    task automatic release_aclr();
        step();
        step();
        aclr = 1'b0;
        step();
    endtask

    task automatic wait_words(input int target, input int budget, input string tag);
        int n = 0;
        while (m_data.size() < target && n < budget) begin
            step();
            n++;
        end
        check(tag, 64'(m_data.size() >= target), 64'd1);
    endtask

    task automatic check_frame(input string tag, input int base, input int f, input int nw, input int len);
        for (int i = 0; i < nw; i++) begin
            check({tag, "_data"}, m_data[base+i], dw(f, i));
            check({tag, "_sop"}, 64'(m_sop[base+i]), 64'(i == 0));
            check({tag, "_eop"}, 64'(m_eop[base+i]), 64'(i == nw - 1));
            check({tag, "_mod"}, 64'(m_mod[base+i]), (i == nw - 1) ? 64'(len % 8) : 64'd0);
        end
    endtask

    initial begin
        int base;
        int early;
        int n;
        int k;

        aclr     = 1'b1;
        tx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rdreq", 64'(fifo_rdreq), 64'd0);
        check("rst_valid", 64'(tx_valid), 64'd0);
        check("rst_sop", 64'(tx_sop), 64'd0);
        check("rst_eop", 64'(tx_eop), 64'd0);
        check("rst_mod", 64'(tx_mod), 64'd0);
        check("rst_data", tx_data, 64'd0);
        check("rst_len_err", 64'(len_err), 64'd0);
        aclr = 1'b0;
        step();

        // len=64, resident before the header is seen: exact cycle timing
        tx_ready = 1'b1;
        base = m_data.size();
        load_frame(1, 64, 8);
        #1;
        check("t1_c0_rdreq", 64'(fifo_rdreq), 64'd1);
        step();
        check("t1_c1_rdreq", 64'(fifo_rdreq), 64'd0);
        step();
        check("t1_c2_rdreq", 64'(fifo_rdreq), 64'd0);
        step();
        check("t1_c3_rdreq", 64'(fifo_rdreq), 64'd1);
        check("t1_c3_valid", 64'(tx_valid), 64'd0);
        for (int c = 4; c <= 12; c++) begin
            step();
            check("t1_rdreq", 64'(fifo_rdreq), 64'(c <= 10));
            check("t1_valid", 64'(tx_valid), 64'(c <= 11));
            if (c <= 11) begin
                check("t1_data", tx_data, dw(1, c - 4));
                check("t1_sop", 64'(tx_sop), 64'(c == 4));
                check("t1_eop", 64'(tx_eop), 64'(c == 11));
                check("t1_mod", 64'(tx_mod), 64'd0);
            end
        end
        check("t1_count", 64'(m_data.size()), 64'(base + 8));

        // len=61: partial eop word; then a single-word frame
        base = m_data.size();
        load_frame(2, 61, 8);
        wait_words(base + 8, 40, "t2_timeout");
        check_frame("t2", base, 2, 8, 61);
        base = m_data.size();
        load_frame(3, 5, 1);
        wait_words(base + 1, 20, "t2b_timeout");
        check_frame("t2b", base, 3, 1, 5);

        // len=1000 trickled in: nothing leaves until all 125 words are stored
        base = m_data.size();
        early = 0;
        push(hdr(1000));
        repeat (6) step();
        for (int i = 0; i < 125; i++) begin
            push(dw(4, i));
            if (i < 124) begin
                repeat (4) begin
                    step();
                    if (tx_valid || fifo_rdreq) early++;
                end
            end
        end
        check("t3_wait_quiet", 64'(early), 64'd0);
        wait_words(base + 125, 200, "t3_timeout");
        check_frame("t3", base, 4, 125, 1000);
        check("t3_back_to_back", 64'(m_cyc[base+124] - m_cyc[base]), 64'd124);

        // len=64 with tx_ready toggling 1,0,0,1
        base = m_data.size();
        load_frame(5, 64, 8);
        k = 0;
        n = 0;
        while (m_data.size() < base + 8 && n < 200) begin
            tx_ready = (k % 4 == 0) || (k % 4 == 3);
            k++;
            step();
            n++;
        end
        tx_ready = 1'b1;
        check("t4_timeout", 64'(m_data.size() >= base + 8), 64'd1);
        repeat (3) step();
        check("t4_count", 64'(m_data.size()), 64'(base + 8));
        check_frame("t4", base, 5, 8, 64);
        check("t4_hold_stable", 64'(hold_err), 64'd0);
        check("t4_occ_le2", 64'(max_occ <= 2), 64'd1);

        // len=0: sticky error, no further reads
        push(hdr(0));
        push(dw(6, 0));
        push(dw(6, 1));
        #1;
        check("t5a_hdr_rdreq", 64'(fifo_rdreq), 64'd1);
        step();
        check("t5a_hdr_no_err_yet", 64'(len_err), 64'd0);
        step();
        check("t5a_len_err", 64'(len_err), 64'd1);
        early = 0;
        repeat (10) begin
            step();
            if (fifo_rdreq || tx_valid) early++;
        end
        check("t5a_quiet", 64'(early), 64'd0);
        check("t5a_no_reads", 64'(fifo_rdusedw), 64'd2);
        check("t5a_still_err", 64'(len_err), 64'd1);
        pulse_aclr();
        check("t5a_aclr_clears", 64'(len_err), 64'd0);
        release_aclr();

        // len=8185: one byte over the limit
        push(hdr(8185));
        push(dw(6, 2));
        #1;
        check("t5b_idle_after_aclr", 64'(fifo_rdreq), 64'd1);
        step();
        step();
        check("t5b_len_err", 64'(len_err), 64'd1);
        early = 0;
        repeat (8) begin
            step();
            if (fifo_rdreq || tx_valid) early++;
        end
        check("t5b_quiet", 64'(early), 64'd0);
        pulse_aclr();
        check("t5b_aclr_clears", 64'(len_err), 64'd0);
        release_aclr();

        // len=8184 is legal: no error, waits for the frame
        push(hdr(8184));
        #1;
        check("t5c_rdreq", 64'(fifo_rdreq), 64'd1);
        step();
        step();
        check("t5c_no_err", 64'(len_err), 64'd0);
        check("t5c_waiting", 64'(tx_valid), 64'd0);
        pulse_aclr();
        release_aclr();

        // two frames back-to-back, third aborted by aclr on its second word
        base = m_data.size();
        load_frame(7, 16, 2);
        load_frame(8, 9, 2);
        load_frame(9, 64, 8);
        wait_words(base + 4, 60, "t6_timeout");
        check_frame("t6a", base, 7, 2, 16);
        check_frame("t6b", base + 2, 8, 2, 9);
        check("t6_gap", 64'(m_cyc[base+2] - m_cyc[base+1]), 64'd5);
        wait_words(base + 5, 30, "t6c_timeout");
        check("t6c_w1", m_data[base+4], dw(9, 0));
        check("t6c_w2_valid", 64'(tx_valid), 64'd1);
        check("t6c_w2_data", tx_data, dw(9, 1));
        pulse_aclr();
        check("t6_aclr_valid", 64'(tx_valid), 64'd0);
        check("t6_aclr_data", tx_data, 64'd0);
        check("t6_aclr_framing", 64'({tx_sop, tx_eop, tx_mod}), 64'd0);
        check("t6_aclr_rdreq", 64'(fifo_rdreq), 64'd0);
        release_aclr();
        repeat (20) step();
        check("t6_nothing_after", 64'(m_data.size()), 64'(base + 5));
        check("t6_idle_valid", 64'(tx_valid), 64'd0);
        check("t6_idle_rdreq", 64'(fifo_rdreq), 64'd0);

        check("no_empty_read", 64'(bad_read), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
